// File: rtl/agg_cls_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : agg_cls_pkg
//  Description : Shared constants and helpers for the aggregation stream
//                classifier: FSM state encoding, match-mode selectors and a
//                constant-foldable clog2.
//  Revision    : 1.0 - initial release
// ============================================================================
package agg_cls_pkg;

    // Classifier FSM state encoding
    localparam int         c_st_w     = 2;
    localparam logic [1:0] c_st_parse = 2'd0;
    localparam logic [1:0] c_st_fwd   = 2'd1;
    localparam logic [1:0] c_st_drop  = 2'd2;

    // Rule combination modes: ethertype AND appcode, or ethertype OR appcode
    localparam int c_match_and = 0;
    localparam int c_match_or  = 1;

    // Ceiling log2, usable in parameter/localparam expressions
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage : agg_cls_pkg
`default_nettype wire

// File: rtl/agg_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : agg_skid_buffer
//  Description : Two-entry AXI-Stream skid buffer. Ready depends only on
//                occupancy, so a stalled consumer never creates a
//                combinational path back to the producer. A beat pushed in
//                cycle N is at the head in cycle N+1.
//  Revision    : 1.0 - initial release
// ============================================================================
module agg_skid_buffer #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_s_valid,
    output logic                 o_s_ready,
    input  logic [PAYLOAD_W-1:0] i_s_payload,
    output logic                 o_m_valid,
    input  logic                 i_m_pop,
    output logic [PAYLOAD_W-1:0] o_m_payload
);

    logic [PAYLOAD_W-1:0] r_mem [0:1];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [1:0]           r_count;
    logic                 r_ready_en;
    logic                 w_push;
    logic                 w_pop;

    // Ready is held low in reset and until the first clock after release
    assign o_s_ready   = r_ready_en && (r_count != 2'd2);
    assign o_m_valid   = (r_count != 2'd0);
    assign o_m_payload = r_mem[r_rd_ptr];
    assign w_push      = i_s_valid && o_s_ready;
    assign w_pop       = i_m_pop && o_m_valid;

    // Pointer, occupancy and ready-enable bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage; contents are don't-care while the entry is empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_s_payload;
        end
    end

endmodule : agg_skid_buffer
`default_nettype wire

// File: rtl/agg_stream_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : agg_stream_classifier
//  Description : Classifies each AXI-Stream packet on its first beat against
//                a programmable rule table and steers the whole packet to one
//                of NUM_CH master ports, or drops it. Keeps per-channel
//                saturating packet counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module agg_stream_classifier
    import agg_cls_pkg::*;
#(
    parameter int  C_AXIS_DATA_WIDTH  = 256,
    parameter int  C_AXIS_TUSER_WIDTH = 128,
    parameter int  NUM_CH             = 4,
    parameter int  NUM_RULES          = 4,
    parameter int  ETHER_TYPE_POS     = 96,
    parameter int  APP_CODE_POS       = 112,
    parameter int  MATCH_MODE         = 0,
    parameter int  DEFAULT_CH         = 0,
    parameter int  DROP_ON_MISS       = 0,
    parameter int  CNT_WIDTH          = 32,
    localparam int c_dest_w           = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH)
) (
    input  logic                                   axis_aclk,
    input  logic                                   axis_resetn,

    input  logic [C_AXIS_DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]         s_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]          s_axis_tuser,
    input  logic                                   s_axis_tvalid,
    output logic                                   s_axis_tready,
    input  logic                                   s_axis_tlast,

    output logic [NUM_CH*C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [NUM_CH*C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [NUM_CH*C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic [NUM_CH-1:0]                      m_axis_tvalid,
    input  logic [NUM_CH-1:0]                      m_axis_tready,
    output logic [NUM_CH-1:0]                      m_axis_tlast,

    input  logic [NUM_RULES-1:0]                   rule_en,
    input  logic [NUM_RULES*16-1:0]                rule_ethertype,
    input  logic [NUM_RULES*16-1:0]                rule_etype_mask,
    input  logic [NUM_RULES*2-1:0]                 rule_appcode,
    input  logic [NUM_RULES*2-1:0]                 rule_app_mask,
    input  logic [NUM_RULES*c_dest_w-1:0]          rule_dest,

    input  logic                                   clear_counters,
    output logic [CNT_WIDTH-1:0]                   pkt_in_cnt,
    output logic [NUM_CH*CNT_WIDTH-1:0]            pkt_out_cnt,
    output logic [CNT_WIDTH-1:0]                   pkt_drop_cnt
);

    localparam int c_dw = C_AXIS_DATA_WIDTH;
    localparam int c_kw = C_AXIS_DATA_WIDTH / 8;
    localparam int c_uw = C_AXIS_TUSER_WIDTH;
    localparam int c_pw = 1 + c_uw + c_kw + c_dw;

    // ------------------------------------------------------------------
    // Input skid buffer
    // ------------------------------------------------------------------
    logic [c_pw-1:0]     w_in_payload;
    logic [c_pw-1:0]     w_head_payload;
    logic                w_head_valid;
    logic                w_pop;
    logic [c_dw-1:0]     w_head_data;
    logic [c_kw-1:0]     w_head_keep;
    logic [c_uw-1:0]     w_head_user;
    logic                w_head_last;

    assign w_in_payload = {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};

    agg_skid_buffer #(
        .PAYLOAD_W (c_pw)
    ) u_skid (
        .clk         (axis_aclk),
        .rst_n       (axis_resetn),
        .i_s_valid   (s_axis_tvalid),
        .o_s_ready   (s_axis_tready),
        .i_s_payload (w_in_payload),
        .o_m_valid   (w_head_valid),
        .i_m_pop     (w_pop),
        .o_m_payload (w_head_payload)
    );

    assign {w_head_last, w_head_user, w_head_keep, w_head_data} = w_head_payload;

    // ------------------------------------------------------------------
    // Rule match on the head beat (fields taken without byte swapping)
    // ------------------------------------------------------------------
    logic [15:0]          w_etype;
    logic [1:0]           w_appcode;
    logic [NUM_RULES-1:0] w_hit;

    assign w_etype   = w_head_data[ETHER_TYPE_POS +: 16];
    assign w_appcode = w_head_data[APP_CODE_POS +: 2];

    generate
        for (genvar i = 0; i < NUM_RULES; i++) begin : g_rule
            logic w_et_hit;
            logic w_ac_hit;
            assign w_et_hit = ((w_etype ^ rule_ethertype[i*16 +: 16])
                               & rule_etype_mask[i*16 +: 16]) == 16'd0;
            assign w_ac_hit = ((w_appcode ^ rule_appcode[i*2 +: 2])
                               & rule_app_mask[i*2 +: 2]) == 2'd0;
            assign w_hit[i] = rule_en[i] &&
                              ((MATCH_MODE == c_match_or) ? (w_et_hit || w_ac_hit)
                                                          : (w_et_hit && w_ac_hit));
        end
    endgenerate

    logic                w_any_hit;
    logic [c_dest_w-1:0] w_hit_dest;
    logic                w_fwd;
    logic [c_dest_w-1:0] w_dest;

    // Lowest-index hit wins: scan from the top so lower indices overwrite
    always_comb begin
        w_any_hit  = 1'b0;
        w_hit_dest = '0;
        for (int i = NUM_RULES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_any_hit  = 1'b1;
                w_hit_dest = rule_dest[i*c_dest_w +: c_dest_w];
            end
        end
    end

    // Forward/drop decision; an out-of-range destination means drop
    always_comb begin
        w_fwd  = 1'b0;
        w_dest = '0;
        if (w_any_hit) begin
            if (int'(w_hit_dest) < NUM_CH) begin
                w_fwd  = 1'b1;
                w_dest = w_hit_dest;
            end
        end else if ((DROP_ON_MISS == 0) && (DEFAULT_CH < NUM_CH)) begin
            w_fwd  = 1'b1;
            w_dest = c_dest_w'(DEFAULT_CH);
        end
    end

    // ------------------------------------------------------------------
    // Packet steering FSM
    // ------------------------------------------------------------------
    logic [c_st_w-1:0]   r_state;
    logic [c_st_w-1:0]   w_state_nxt;
    logic [c_dest_w-1:0] r_cur_dest;
    logic [c_dest_w-1:0] w_cur_dest_nxt;
    logic [NUM_CH-1:0]   w_valid_vec;
    logic                w_drop_last;

    // State and latched destination; held for the whole packet in flight
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_state    <= c_st_parse;
            r_cur_dest <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_dest <= w_cur_dest_nxt;
        end
    end

    // Next state, head pop and per-channel valid
    always_comb begin
        w_state_nxt    = r_state;
        w_cur_dest_nxt = r_cur_dest;
        w_pop          = 1'b0;
        w_valid_vec    = '0;
        w_drop_last    = 1'b0;
        case (r_state)
            c_st_parse: begin
                if (w_head_valid) begin
                    if (w_fwd) begin
                        w_valid_vec[w_dest] = 1'b1;
                        if (m_axis_tready[w_dest]) begin
                            w_pop = 1'b1;
                            if (!w_head_last) begin
                                w_state_nxt    = c_st_fwd;
                                w_cur_dest_nxt = w_dest;
                            end
                        end
                    end else begin
                        w_pop = 1'b1;
                        if (w_head_last) begin
                            w_drop_last = 1'b1;
                        end else begin
                            w_state_nxt = c_st_drop;
                        end
                    end
                end
            end
            c_st_fwd: begin
                w_valid_vec[r_cur_dest] = w_head_valid;
                if (w_head_valid && m_axis_tready[r_cur_dest]) begin
                    w_pop = 1'b1;
                    if (w_head_last) begin
                        w_state_nxt = c_st_parse;
                    end
                end
            end
            c_st_drop: begin
                if (w_head_valid) begin
                    w_pop = 1'b1;
                    if (w_head_last) begin
                        w_drop_last = 1'b1;
                        w_state_nxt = c_st_parse;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_parse;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output fan-out: every channel sees the head beat, only valid differs
    // ------------------------------------------------------------------
    assign m_axis_tvalid = w_valid_vec;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            assign m_axis_tdata[c*c_dw +: c_dw] = w_head_data;
            assign m_axis_tkeep[c*c_kw +: c_kw] = w_head_keep;
            assign m_axis_tuser[c*c_uw +: c_uw] = w_head_user;
            assign m_axis_tlast[c]              = w_head_last;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Saturating packet counters; clear wins over a same-cycle increment
    // ------------------------------------------------------------------
    logic                 w_in_last_hs;
    logic [CNT_WIDTH-1:0] r_in_cnt;
    logic [CNT_WIDTH-1:0] r_drop_cnt;

    assign w_in_last_hs = s_axis_tvalid && s_axis_tready && s_axis_tlast;
    assign pkt_in_cnt   = r_in_cnt;
    assign pkt_drop_cnt = r_drop_cnt;

    // Accepted-packet counter
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_in_cnt <= '0;
        end else if (clear_counters) begin
            r_in_cnt <= '0;
        end else if (w_in_last_hs && !(&r_in_cnt)) begin
            r_in_cnt <= r_in_cnt + 1'b1;
        end
    end

    // Dropped-packet counter
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_drop_cnt <= '0;
        end else if (clear_counters) begin
            r_drop_cnt <= '0;
        end else if (w_drop_last && !(&r_drop_cnt)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_out_cnt
            logic                 r_cnt;
            logic [CNT_WIDTH-1:0] r_cnt_val;
            logic                 w_inc;
            assign w_inc = w_valid_vec[c] && m_axis_tready[c] && w_head_last;
            assign pkt_out_cnt[c*CNT_WIDTH +: CNT_WIDTH] = r_cnt_val;
            assign r_cnt = 1'b0;

            // Emitted-packet counter for this channel
            always_ff @(posedge axis_aclk or negedge axis_resetn) begin
                if (!axis_resetn) begin
                    r_cnt_val <= '0;
                end else if (clear_counters) begin
                    r_cnt_val <= '0;
                end else if (w_inc && !(&r_cnt_val)) begin
                    r_cnt_val <= r_cnt_val + 1'b1;
                end
            end
        end
    endgenerate

endmodule : agg_stream_classifier
`default_nettype wire

// File: tb/tb_agg_stream_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_agg_stream_classifier
//  Description : Directed self-checking bench for agg_stream_classifier.
//                A second instance with DROP_ON_MISS=1 covers the drop path.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_agg_stream_classifier;

    logic         axis_aclk   = 1'b0;
    logic         axis_resetn = 1'b0;

    logic [255:0] s_tdata  = '0;
    logic [31:0]  s_tkeep  = '1;
    logic [127:0] s_tuser  = '0;
    logic         s_tlast  = 1'b0;
    logic         tv1      = 1'b0;
    logic         tv2      = 1'b0;
    wire          rdy1;
    wire          rdy2;

    wire  [1023:0] m_tdata1,  m_tdata2;
    wire  [127:0]  m_tkeep1,  m_tkeep2;
    wire  [511:0]  m_tuser1,  m_tuser2;
    wire  [3:0]    m_tvalid1, m_tvalid2;
    wire  [3:0]    m_tlast1,  m_tlast2;
    logic [3:0]    m_tready1 = 4'hF;
    logic [3:0]    m_tready2 = 4'hF;

    // Rule table: r0 8888/app0->2, r1 1111->1, r2 3333->3, r3 1111->3
    logic [3:0]  rule_en         = 4'hF;
    logic [63:0] rule_ethertype  = {16'h1111, 16'h3333, 16'h1111, 16'h8888};
    logic [63:0] rule_etype_mask = {4{16'hFFFF}};
    logic [7:0]  rule_appcode    = 8'h00;
    logic [7:0]  rule_app_mask   = {2'b00, 2'b00, 2'b00, 2'b11};
    logic [7:0]  rule_dest       = {2'd3, 2'd3, 2'd1, 2'd2};
    logic        clear_counters  = 1'b0;

    wire [31:0]  in_cnt1, drop_cnt1, in_cnt2, drop_cnt2;
    wire [127:0] out_cnt1, out_cnt2;

    always #5 axis_aclk = ~axis_aclk;

    agg_stream_classifier u_dut (
        .axis_aclk (axis_aclk), .axis_resetn (axis_resetn),
        .s_axis_tdata (s_tdata), .s_axis_tkeep (s_tkeep), .s_axis_tuser (s_tuser),
        .s_axis_tvalid (tv1), .s_axis_tready (rdy1), .s_axis_tlast (s_tlast),
        .m_axis_tdata (m_tdata1), .m_axis_tkeep (m_tkeep1), .m_axis_tuser (m_tuser1),
        .m_axis_tvalid (m_tvalid1), .m_axis_tready (m_tready1), .m_axis_tlast (m_tlast1),
        .rule_en (rule_en), .rule_ethertype (rule_ethertype), .rule_etype_mask (rule_etype_mask),
        .rule_appcode (rule_appcode), .rule_app_mask (rule_app_mask), .rule_dest (rule_dest),
        .clear_counters (clear_counters), .pkt_in_cnt (in_cnt1), .pkt_out_cnt (out_cnt1),
        .pkt_drop_cnt (drop_cnt1)
    );

    agg_stream_classifier #(.DROP_ON_MISS (1)) u_dut_drop (
        .axis_aclk (axis_aclk), .axis_resetn (axis_resetn),
        .s_axis_tdata (s_tdata), .s_axis_tkeep (s_tkeep), .s_axis_tuser (s_tuser),
        .s_axis_tvalid (tv2), .s_axis_tready (rdy2), .s_axis_tlast (s_tlast),
        .m_axis_tdata (m_tdata2), .m_axis_tkeep (m_tkeep2), .m_axis_tuser (m_tuser2),
        .m_axis_tvalid (m_tvalid2), .m_axis_tready (m_tready2), .m_axis_tlast (m_tlast2),
        .rule_en (rule_en), .rule_ethertype (rule_ethertype), .rule_etype_mask (rule_etype_mask),
        .rule_appcode (rule_appcode), .rule_app_mask (rule_app_mask), .rule_dest (rule_dest),
        .clear_counters (clear_counters), .pkt_in_cnt (in_cnt2), .pkt_out_cnt (out_cnt2),
        .pkt_drop_cnt (drop_cnt2)
    );

    typedef struct packed {
        logic [3:0]   ch;
        logic         last;
        logic [255:0] data;
    } beat_t;

    beat_t exp_q[$];
    beat_t rx_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc   = 0;
    int    in_hs = 0;
    bit    onehot_bad  = 1'b0;
    bit    valid2_seen = 1'b0;
    bit    rdy2_low    = 1'b0;
    bit    win2        = 1'b0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mk_beat(input logic [15:0] et, input logic [1:0] ac,
                                             input int tag);
        logic [255:0] d;
        d = {8{32'(tag)}};
        d[96 +: 16] = et;
        d[112 +: 2] = ac;
        return d;
    endfunction

    always @(posedge axis_aclk) cyc++;

    // Output capture and sticky protocol observations, sampled mid-cycle
    always @(negedge axis_aclk) begin
        if (axis_resetn) begin
            for (int c = 0; c < 4; c++) begin
                if (m_tvalid1[c] && m_tready1[c])
                    rx_q.push_back('{ch: 4'(c), last: m_tlast1[c], data: m_tdata1[c*256 +: 256]});
            end
            if (!$onehot0(m_tvalid1)) onehot_bad = 1'b1;
            if (|m_tvalid2) valid2_seen = 1'b1;
            if (win2 && !rdy2) rdy2_low = 1'b1;
            if (tv1 && rdy1) in_hs++;
        end
    end

    // Send one packet; dest < 0 means no output is expected
    task automatic send_pkt(input logic [15:0] et, input logic [1:0] ac, input int nb,
                            input int tag, input int dest, input bit to2);
        for (int j = 0; j < nb; j++) begin
            int  n;
            bit  ok;
            s_tdata = mk_beat(et, ac, tag + j);
            s_tuser = {4{32'(tag + j)}};
            s_tlast = (j == nb - 1);
            if (to2) tv2 = 1'b1; else tv1 = 1'b1;
            if (dest >= 0 && !to2)
                exp_q.push_back('{ch: 4'(dest), last: (j == nb - 1), data: s_tdata});
            n  = 0;
            ok = 1'b0;
            while (!ok && n < 200) begin
                @(negedge axis_aclk);
                ok = to2 ? rdy2 : rdy1;
                @(posedge axis_aclk);
                #1;
                n++;
            end
            if (!ok) chk("send_timeout", 0, 1);
        end
        tv1 = 1'b0;
        tv2 = 1'b0;
        s_tlast = 1'b0;
    endtask

    task automatic drain();
        repeat (6) @(posedge axis_aclk);
        #1;
    endtask

    task automatic sb_check(input string tag);
        int n;
        chk({tag, "_nbeats"}, rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_ch"},   rx_q[i].ch,   exp_q[i].ch);
            chk({tag, "_data"}, rx_q[i].data, exp_q[i].data);
            chk({tag, "_last"}, rx_q[i].last, exp_q[i].last);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int c0;
        int hs0;
        int hs_delta;
        bit saw_low;
        hs_delta = 0;
        saw_low  = 1'b0;

        // Reset state
        repeat (3) @(posedge axis_aclk);
        #1;
        chk("rst_tready", rdy1, 0);
        chk("rst_tvalid", m_tvalid1, 0);
        chk("rst_in_cnt", in_cnt1, 0);
        chk("rst_out_cnt", out_cnt1, 0);
        axis_resetn = 1'b1;
        repeat (2) @(posedge axis_aclk);
        #1;
        chk("post_rst_tready", rdy1, 1);

        // Rule 0 hit: 4-beat packet to channel 2
        send_pkt(16'h8888, 2'd0, 4, 'h100, 2, 1'b0);
        drain();
        sb_check("rule0");
        chk("rule0_in_cnt", in_cnt1, 1);
        chk("rule0_out2", out_cnt1[64 +: 32], 1);
        chk("rule0_out0", out_cnt1[0 +: 32], 0);

        // Miss goes to default channel 0
        send_pkt(16'h0800, 2'd0, 2, 'h200, 0, 1'b0);
        drain();
        sb_check("miss_default");
        chk("miss_out0", out_cnt1[0 +: 32], 1);

        // Miss with DROP_ON_MISS=1: dropped, ready stays high
        win2 = 1'b1;
        send_pkt(16'h0800, 2'd0, 3, 'h300, -1, 1'b1);
        drain();
        win2 = 1'b0;
        chk("drop_cnt", drop_cnt2, 1);
        chk("drop_in_cnt", in_cnt2, 1);
        chk("drop_no_tvalid", valid2_seen, 0);
        chk("drop_tready_high", rdy2_low, 0);
        chk("drop_out_cnt", out_cnt2, 0);
        chk("nodrop_inst_drop_cnt", drop_cnt1, 0);

        // Rules 1 and 3 both hit: lower index (dest 1) wins
        send_pkt(16'h1111, 2'd1, 3, 'h400, 1, 1'b0);
        drain();
        sb_check("priority");
        chk("prio_out1", out_cnt1[32 +: 32], 1);
        chk("prio_out3", out_cnt1[96 +: 32], 0);

        // Channel 2 stalled 10 cycles mid-packet
        fork
            send_pkt(16'h8888, 2'd0, 8, 'h500, 2, 1'b0);
            begin : stall
                int n;
                n = 0;
                while (rx_q.size() < 2 && n < 200) begin
                    @(negedge axis_aclk);
                    n++;
                end
                @(posedge axis_aclk);
                #1;
                m_tready1[2] = 1'b0;
                hs0 = in_hs;
                repeat (10) begin
                    @(negedge axis_aclk);
                    if (!rdy1) saw_low = 1'b1;
                end
                hs_delta = in_hs - hs0;
                @(posedge axis_aclk);
                #1;
                m_tready1[2] = 1'b1;
            end
        join
        drain();
        sb_check("stall");
        chk("stall_tready_dropped", saw_low, 1);
        chk("stall_accept_le2", (hs_delta <= 2), 1);
        chk("stall_out2", out_cnt1[64 +: 32], 2);

        // Back-to-back single-beat packets alternating 0/3
        c0 = cyc;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 1) send_pkt(16'h3333, 2'd0, 1, 'h600 + k, 3, 1'b0);
            else            send_pkt(16'h0800, 2'd0, 1, 'h600 + k, 0, 1'b0);
        end
        chk("b2b_cycles", cyc - c0, 8);
        drain();
        sb_check("b2b");
        chk("b2b_in_cnt", in_cnt1, 12);
        chk("b2b_out3", out_cnt1[96 +: 32], 4);
        chk("tvalid_onehot", onehot_bad, 0);

        // Reset in the middle of a packet stalled on channel 2
        m_tready1[2] = 1'b0;
        s_tdata = mk_beat(16'h8888, 2'd0, 'h700);
        s_tlast = 1'b0;
        tv1 = 1'b1;
        repeat (4) @(posedge axis_aclk);
        #1;
        chk("mid_tvalid", m_tvalid1, 4'b0100);
        chk("mid_tready_full", rdy1, 0);
        #2;
        axis_resetn = 1'b0;
        #1;
        chk("async_rst_tvalid", m_tvalid1, 0);
        chk("async_rst_in_cnt", in_cnt1, 0);
        chk("async_rst_out_cnt", out_cnt1, 0);
        tv1 = 1'b0;
        @(posedge axis_aclk);
        #1;
        axis_resetn  = 1'b1;
        m_tready1    = 4'hF;
        rx_q.delete();
        exp_q.delete();
        repeat (2) @(posedge axis_aclk);
        #1;
        send_pkt(16'h1111, 2'd0, 2, 'h800, 1, 1'b0);
        drain();
        sb_check("after_rst");
        chk("after_rst_in_cnt", in_cnt1, 1);
        chk("after_rst_out1", out_cnt1[32 +: 32], 1);
        chk("after_rst_out2", out_cnt1[64 +: 32], 0);

        // clear_counters coincident with an input tlast handshake
        s_tdata = mk_beat(16'h0800, 2'd0, 'h900);
        s_tuser = '0;
        s_tlast = 1'b1;
        tv1 = 1'b1;
        clear_counters = 1'b1;
        exp_q.push_back('{ch: 4'd0, last: 1'b1, data: s_tdata});
        @(negedge axis_aclk);
        chk("clr_tready", rdy1, 1);
        @(posedge axis_aclk);
        #1;
        tv1 = 1'b0;
        s_tlast = 1'b0;
        clear_counters = 1'b0;
        chk("clr_in_cnt", in_cnt1, 0);
        chk("clr_out1", out_cnt1[32 +: 32], 0);
        drain();
        sb_check("clr");
        chk("clr_out0_after", out_cnt1[0 +: 32], 1);
        chk("clr_in_cnt_after", in_cnt1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_agg_stream_classifier
`default_nettype wire

// File: doc/agg_stream_classifier.md
Name: agg_stream_classifier

Overview:
- Parametrised successor to the two-way aggregation parser.
- Classifies each AXI-Stream packet on its first beat against a programmable rule table, then steers the whole packet to one of NUM_CH master ports or drops it.
- Sits between the RX queue arbiter and the aggregation pipelines / output queues.
- Provides per-channel packet counters for the CPU register block.

Parameters:
- C_AXIS_DATA_WIDTH, 256, tdata width; tkeep is /8.
- C_AXIS_TUSER_WIDTH, 128, tuser width.
- NUM_CH, 4, number of master output channels (2..8).
- NUM_RULES, 4, match rules (1..8); lowest index has priority.
- ETHER_TYPE_POS, 96, bit offset of the 16-bit ethertype field in beat 0; must satisfy ETHER_TYPE_POS+16 <= data width.
- APP_CODE_POS, 112, bit offset of the 2-bit app code in beat 0.
- MATCH_MODE, 0, 0 = ethertype AND appcode must both match; 1 = either matches.
- DEFAULT_CH, 0, channel used on a rule miss when DROP_ON_MISS=0.
- DROP_ON_MISS, 0, 1 = discard packets that hit no rule.
- CNT_WIDTH, 32, counter width.

Ports:
- axis_aclk  in  1  clock.
- axis_resetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  DW  input data.
- s_axis_tkeep  in  DW/8  input keep.
- s_axis_tuser  in  TUW  input user.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  input last.
- m_axis_tdata  out  NUM_CH*DW  per-channel data; all channels carry the same data.
- m_axis_tkeep  out  NUM_CH*DW/8  per-channel keep.
- m_axis_tuser  out  NUM_CH*TUW  per-channel user.
- m_axis_tvalid  out  NUM_CH  one-hot or zero.
- m_axis_tready  in  NUM_CH  per-channel ready.
- m_axis_tlast  out  NUM_CH  per-channel last.
- rule_en  in  NUM_RULES  rule enable.
- rule_ethertype  in  NUM_RULES*16  ethertype value per rule.
- rule_etype_mask  in  NUM_RULES*16  care bits; 1 = compare.
- rule_appcode  in  NUM_RULES*2  appcode value per rule.
- rule_app_mask  in  NUM_RULES*2  care bits.
- rule_dest  in  NUM_RULES*clog2(NUM_CH)  destination channel per rule.
- clear_counters  in  1  synchronous clear pulse.
- pkt_in_cnt  out  CNT_WIDTH  packets accepted.
- pkt_out_cnt  out  NUM_CH*CNT_WIDTH  packets emitted per channel.
- pkt_drop_cnt  out  CNT_WIDTH  packets dropped.

Behaviour:
- Reset (async assert, sync release):
  - state=PARSE, hold buffer empty, all m_axis_tvalid=0, s_axis_tready=0 while reset asserted, all counters=0.
  - Reset mid-packet discards the partial packet; no tlast is emitted.
- Input stage is a 2-entry skid buffer.
  - s_axis_tready=1 while fewer than 2 entries are occupied.
  - A beat accepted at cycle N is visible at the head at N+1.
  - Full throughput is 1 beat/cycle.
- Per-rule hit, evaluated on the head beat:
  - et_hit = ((etype ^ rule_ethertype[i]) & rule_etype_mask[i]) == 0.
  - ac_hit is the same comparison on the appcode fields.
  - hit[i] = rule_en[i] & (MATCH_MODE ? et_hit|ac_hit : et_hit&ac_hit).
- Fields are taken unswapped: etype = head_tdata[ETHER_TYPE_POS +: 16], appcode = head_tdata[APP_CODE_POS +: 2].
- Decision:
  - The lowest-index hit gives dest.
  - With no hit, dest = DEFAULT_CH, or drop if DROP_ON_MISS=1.
  - A rule_dest >= NUM_CH is treated as a drop.
- State PARSE, head valid:
  - If forwarding, assert m_axis_tvalid[dest] in the same cycle; classification adds 0 extra cycles.
  - On handshake, pop the head. If tlast, stay in PARSE. Otherwise latch cur_dest and go to FWD.
  - If dropping, pop the head this cycle. If tlast, stay in PARSE. Otherwise go to DROP.
- State FWD:
  - m_axis_tvalid[cur_dest] = head valid; pop on handshake.
  - tlast handshake returns to PARSE.
  - Rules are not re-evaluated; config changes mid-packet have no effect on the packet in flight.
- State DROP:
  - Pop one beat per cycle with no output.
  - Popping tlast returns to PARSE.
- Back-pressure:
  - A stalled destination blocks only the head. No beat is reordered or duplicated.
  - tvalid stays asserted and the data stays stable until tready.
- Counters:
  - pkt_in_cnt increments on an input tlast handshake.
  - pkt_out_cnt[c] increments on a channel c tlast handshake.
  - pkt_drop_cnt increments when tlast is popped in drop.
  - All counters saturate at all-ones.
  - clear_counters has priority over a same-cycle increment; the result is 0.
- A single-beat packet (tlast on beat 0) is classified and completed in one handshake.

Decomposition:
- Package agg_cls_pkg:
  - state encoding localparams (PARSE, FWD, DROP);
  - MATCH_AND / MATCH_OR constants;
  - clog2 function.
- Sub-module agg_skid_buffer: 2-entry AXI-Stream skid buffer, parameterised on payload width, carrying {tlast, tuser, tkeep, tdata}.
- Match logic and FSM stay in the top module.

Test Plan:
- Rule0 = {etype 0x8888 mask 0xFFFF, appcode 0 mask 3, dest 2}, MATCH_MODE=0; send a 4-beat packet with etype 0x8888, appcode 0 -> 4 beats on channel 2 only; pkt_out_cnt[2]=1, pkt_in_cnt=1.
- Same rule; packet with etype 0x0800 -> forwarded to DEFAULT_CH=0. Rerun with DROP_ON_MISS=1 -> no output tvalid, pkt_drop_cnt=1, s_axis_tready stays high.
- Rules 1 and 3 both hit with dests 1 and 3 -> packet goes to channel 1 (priority).
- Channel 2 tready held low for 10 cycles mid-packet -> at most 2 beats buffered, s_axis_tready drops, no beat lost; output sequence is identical to input.
- Back-to-back single-beat packets alternating destinations 0/3 -> 1 beat/cycle sustained, tvalid one-hot each cycle.
- axis_resetn asserted mid-packet -> all tvalid=0 asynchronously, counters=0, next packet is classified from its first beat; clear_counters coincident with a tlast handshake -> counter reads 0.
